// File: rtl/multi_debouncer_pkg.sv
// rtl/multi_debouncer_pkg.sv - shared defaults, channel action type and parameter check
//
// Holds the default channel count, counter width and flip limit shared by the
// display and button-input blocks. Also defines the per-edge action type used
// inside each debounce channel.
package multi_debouncer_pkg;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_CNT_W    = 4;
  localparam int DEF_LIMIT    = 15;

  // What a channel does on one clock edge. The values are listed from
  // highest to lowest priority.
  typedef enum logic [2:0] {
    ACT_CLEAR   = 3'd0,  // synchronous clear: level and count dropped, no pulse
    ACT_RESTART = 3'd1,  // synced input agrees with level: discard partial count
    ACT_HOLD    = 3'd2,  // disagreeing, but no enable tick this cycle
    ACT_COUNT   = 3'd3,  // disagreeing with enable: one more stable cycle
    ACT_FLIP    = 3'd4   // disagreement lasted LIMIT enabled cycles
  } chan_act_e;

  // LIMIT must fit in the counter without ever wrapping it.
  function automatic bit limit_ok(input int limit, input int cnt_w);
    return (limit >= 1) && (limit <= (2 ** cnt_w) - 1);
  endfunction

endpackage

// File: rtl/multi_debouncer_if.sv
// rtl/multi_debouncer_if.sv - control and data bundle between the debouncer and its user
//
// master: drives sclr, en and the raw inputs din; observes the debounced outputs.
// slave : the debouncer, which receives the controls and produces level/rise/fall.
interface multi_debouncer_if #(
  parameter int CHANNELS = 4
);
  logic                sclr;
  logic                en;
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

  modport master (
    output sclr, en, din,
    input  level, rise, fall
  );

  modport slave (
    input  sclr, en, din,
    output level, rise, fall
  );
endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounce lane: 2-flop synchroniser, counter, level and pulses
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   sclr       : synchronous clear of count and level (no pulse)
//   en         : count-enable tick
//   din        : raw asynchronous input
//   level      : debounced level (registered)
//   rise, fall : one-cycle pulses aligned with a level change
module debounce_channel
  import multi_debouncer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int LIMIT = DEF_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic sclr,
  input  logic en,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  chan_act_e        act;

  always_comb begin
    // The synchroniser keeps shifting through sclr and en so that the input
    // history is already valid when counting resumes.
    sync1_d = din;
    sync2_d = sync1_q;

    if (sclr)                    act = ACT_CLEAR;
    else if (sync2_q == level_q) act = ACT_RESTART;
    else if (!en)                act = ACT_HOLD;
    else if (cnt_q == CNT_LAST)  act = ACT_FLIP;
    else                         act = ACT_COUNT;

    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (act)
      ACT_CLEAR: begin
        cnt_d   = '0;
        level_d = 1'b0;
      end
      ACT_RESTART: cnt_d = '0;
      ACT_HOLD:    cnt_d = cnt_q;
      ACT_COUNT:   cnt_d = cnt_q + 1'b1;
      ACT_FLIP: begin
        cnt_d   = '0;
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - parametrised multi-channel debouncer with rise/fall pulses
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : multi_debouncer_if slave - sclr, en, din in; level, rise, fall out
// Parameters: CHANNELS (>= 1), CNT_W, LIMIT (1 .. 2^CNT_W-1).
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LIMIT    = DEF_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  multi_debouncer_if.slave  bus
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("multi_debouncer: CHANNELS must be at least 1");
  end

  if (!limit_ok(LIMIT, CNT_W)) begin : g_bad_limit
    $error("multi_debouncer: LIMIT must lie in 1 .. 2**CNT_W-1");
  end

  logic [CHANNELS-1:0] level_w;
  logic [CHANNELS-1:0] rise_w;
  logic [CHANNELS-1:0] fall_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .CNT_W (CNT_W),
      .LIMIT (LIMIT)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .sclr  (bus.sclr),
      .en    (bus.en),
      .din   (bus.din[i]),
      .level (level_w[i]),
      .rise  (rise_w[i]),
      .fall  (fall_w[i])
    );
  end

  assign bus.level = level_w;
  assign bus.rise  = rise_w;
  assign bus.fall  = fall_w;

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - self-checking bench for multi_debouncer (LIMIT=15 and LIMIT=1 builds)
module tb_multi_debouncer;

  localparam int CH   = 4;
  localparam int LIM0 = 15;
  localparam int LIM1 = 1;

  logic          clk;
  logic          reset;
  logic          drv_sclr;
  logic          drv_en;
  logic [CH-1:0] drv_din;

  int n_cmp = 0;
  int n_err = 0;

  multi_debouncer_if #(.CHANNELS(CH)) ifc0 ();
  multi_debouncer_if #(.CHANNELS(CH)) ifc1 ();

  assign ifc0.sclr = drv_sclr;
  assign ifc0.en   = drv_en;
  assign ifc0.din  = drv_din;
  assign ifc1.sclr = drv_sclr;
  assign ifc1.en   = drv_en;
  assign ifc1.din  = drv_din;

  multi_debouncer #(.CHANNELS(CH), .CNT_W(4), .LIMIT(LIM0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc0.slave)
  );

  multi_debouncer #(.CHANNELS(CH), .CNT_W(1), .LIMIT(LIM1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: input seen two edges late, level flips once the
  // disagreement has lasted 'limit' enabled edges without interruption.
  bit [CH-1:0] m_seen1 [2];
  bit [CH-1:0] m_seen2 [2];
  bit [CH-1:0] m_lvl   [2];
  bit [CH-1:0] m_rise  [2];
  bit [CH-1:0] m_fall  [2];
  int          m_run   [2][CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_seen1[d] = '0;
      m_seen2[d] = '0;
      m_lvl[d]   = '0;
      m_rise[d]  = '0;
      m_fall[d]  = '0;
      for (int c = 0; c < CH; c++) m_run[d][c] = 0;
    end
  endtask

  task automatic model_edge();
    int lim;
    if (reset) return;
    for (int d = 0; d < 2; d++) begin
      lim = (d == 0) ? LIM0 : LIM1;
      for (int c = 0; c < CH; c++) begin
        m_rise[d][c] = 1'b0;
        m_fall[d][c] = 1'b0;
        if (drv_sclr) begin
          m_run[d][c] = 0;
          m_lvl[d][c] = 1'b0;
        end else if (m_seen2[d][c] == m_lvl[d][c]) begin
          m_run[d][c] = 0;
        end else if (drv_en) begin
          m_run[d][c] = m_run[d][c] + 1;
          if (m_run[d][c] == lim) begin
            m_run[d][c]  = 0;
            m_lvl[d][c]  = m_seen2[d][c];
            m_rise[d][c] = m_seen2[d][c];
            m_fall[d][c] = !m_seen2[d][c];
          end
        end
      end
      m_seen2[d] = m_seen1[d];
      m_seen1[d] = drv_din;
    end
  endtask

  task automatic compare_all();
    check("level_l15", ifc0.level, m_lvl[0]);
    check("rise_l15",  ifc0.rise,  m_rise[0]);
    check("fall_l15",  ifc0.fall,  m_fall[0]);
    check("level_l1",  ifc1.level, m_lvl[1]);
    check("rise_l1",   ifc1.rise,  m_rise[1]);
    check("fall_l1",   ifc1.fall,  m_fall[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Run up to 'budget' edges; report the first edge index (1-based) on which
  // channel 'ch' pulses (rise or fall) on each build, plus that pulse vector.
  task automatic watch(input int budget, input int ch, input bit want_fall, input bit gated,
                       output int at0, output int at1,
                       output logic [CH-1:0] vec0, output logic [CH-1:0] vec1);
    at0 = -1; at1 = -1; vec0 = '0; vec1 = '0;
    for (int k = 1; k <= budget; k++) begin
      if (gated) drv_en = (k % 4 == 0);
      cycle();
      if (at0 < 0 && (want_fall ? ifc0.fall[ch] : ifc0.rise[ch])) begin
        at0 = k; vec0 = want_fall ? ifc0.fall : ifc0.rise;
      end
      if (at1 < 0 && (want_fall ? ifc1.fall[ch] : ifc1.rise[ch])) begin
        at1 = k; vec1 = want_fall ? ifc1.fall : ifc1.rise;
      end
    end
    if (gated) drv_en = 1'b1;
  endtask

  task automatic async_reset();
    #3;
    reset = 1'b1;
    model_clear();
    #1;
    compare_all();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int a0, a1;
    logic [CH-1:0] v0, v1;

    reset    = 1'b1;
    drv_sclr = 1'b0;
    drv_en   = 1'b1;
    drv_din  = '0;
    model_clear();
    #1;
    compare_all();
    cycle();
    cycle();
    reset = 1'b0;
    repeat (3) cycle();

    // Clean press on channel 0.
    drv_din[0] = 1'b1;
    watch(25, 0, 1'b0, 1'b0, a0, a1, v0, v1);
    check("press_edge_l15", a0, 17);
    check("press_edge_l1",  a1, 3);
    check("press_vec_l15",  v0, 4'b0001);

    // Bounce on channel 1: period-5 toggling, then held high.
    for (int k = 0; k < 60; k++) begin
      if (k % 5 == 0) drv_din[1] = ~drv_din[1];
      cycle();
      check("bounce_no_flip", ifc0.level[1], 1'b0);
    end
    drv_din[1] = 1'b1;
    watch(25, 1, 1'b0, 1'b0, a0, a1, v0, v1);
    check("bounce_edge_l15", a0, 17);
    check("bounce_edge_l1",  a1, 3);

    // Gated enable on channel 2: en high on every fourth edge.
    drv_din[2] = 1'b1;
    watch(70, 2, 1'b0, 1'b1, a0, a1, v0, v1);
    check("gated_edge_l15", a0, 60);
    check("gated_edge_l1",  a1, 4);

    // Synchronous clear while channel 0 is high and din stays high.
    drv_sclr = 1'b1;
    cycle();
    drv_sclr = 1'b0;
    check("sclr_level", ifc0.level[0], 1'b0);
    check("sclr_nofall", ifc0.fall[0], 1'b0);
    watch(20, 0, 1'b0, 1'b0, a0, a1, v0, v1);
    check("sclr_rise_l15", a0, 15);
    check("sclr_rise_l1",  a1, 1);

    // Bring channel 3 up, then release 0 and 3 together.
    drv_din = 4'b1111;
    repeat (20) cycle();
    check("all_high", ifc0.level, 4'b1111);
    drv_din = 4'b0110;
    watch(25, 0, 1'b1, 1'b0, a0, a1, v0, v1);
    check("release_edge_l15", a0, 17);
    check("release_vec_l15",  v0, 4'b1001);
    check("release_edge_l1",  a1, 3);
    check("release_vec_l1",   v1, 4'b1001);

    // Reset in the middle of a count (count at 8 on the LIMIT=15 build).
    drv_din = 4'b1111;
    repeat (10) cycle();
    async_reset();
    watch(25, 0, 1'b0, 1'b0, a0, a1, v0, v1);
    check("post_reset_l15", a0, 17);
    check("post_reset_l1",  a1, 3);

    // Randomised traffic: slow-changing inputs, sparse en gaps, rare sclr/reset.
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 19) == 0) drv_din[c] = ~drv_din[c];
      drv_en   = ($urandom_range(0, 3) != 0);
      drv_sclr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 499) == 0) begin
        drv_sclr = 1'b0;
        async_reset();
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
